// File: rtl/vau_pkg.sv
// vau_pkg: shared types, constants and helpers for the vector activation unit.
// Holds the activation-mode enum, the configuration record and a signed saturator.
// The configuration record is sized by the VAU_* constants; top-level widths default to them.
package vau_pkg;

  localparam int VAU_ACC_W   = 32;
  localparam int VAU_OUT_W   = 8;
  localparam int VAU_SHIFT_W = 5;

  // Requantisation scale is Q8.8: 8 fraction bits, round-half-up constant.
  localparam int Q_FRAC  = 8;
  localparam int Q_ROUND = 128;

  typedef enum logic [1:0] {
    ACT_IDENT = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_CLIP  = 2'd2,
    ACT_LEAKY = 2'd3
  } act_mode_e;

  typedef struct packed {
    act_mode_e                         mode;
    logic signed [VAU_ACC_W-1:0]       clip_max;
    logic        [VAU_SHIFT_W-1:0]     leak_shift;
    logic signed [15:0]                gain;
    logic        [VAU_SHIFT_W-1:0]     shift;
    logic signed [VAU_ACC_W-1:0]       bias;
    logic signed [15:0]                inv_scale;
    logic signed [VAU_OUT_W-1:0]       zero_point;
  } vau_cfg_t;

  localparam vau_cfg_t CFG_RESET = '{
    mode:       ACT_IDENT,
    clip_max:   '0,
    leak_shift: '0,
    gain:       16'sd1,
    shift:      '0,
    bias:       '0,
    inv_scale:  16'sd256,
    zero_point: '0
  };

  // Clamp v into the signed range of a w-bit word (w <= 63); clamped flags a clip.
  function automatic logic signed [63:0] sat_signed(
    input  logic signed [63:0] v,
    input  int                 w,
    output logic               clamped
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    clamped    = 1'b0;
    sat_signed = v;
    if (v > hi) begin
      sat_signed = hi;
      clamped    = 1'b1;
    end else if (v < lo) begin
      sat_signed = lo;
      clamped    = 1'b1;
    end
  endfunction

endpackage

// File: rtl/vector_activation_unit_if.sv
// vector_activation_unit_if: upstream and downstream beat streams of the unit.
// Ports: in_valid/in_ready/in_data (accumulator beat), out_valid/out_ready/out_data/out_sat.
// slave is the unit's view of the bus; master is the producer/consumer side.
interface vector_activation_unit_if #(
  parameter int LANES = 4,
  parameter int ACC_W = 32,
  parameter int OUT_W = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*ACC_W-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*OUT_W-1:0] out_data;
  logic [LANES-1:0]       out_sat;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/vau_lane.sv
// vau_lane: one lane's datapath - activation, gain, round/shift/bias, scale, zero point/clamp.
// Latency 5 cycles (one register per stage); all stage registers advance only when en is high.
// Backpressure: en low freezes every stage, so y/sat hold stable.
// Ports: clk, reset_n, en, x (accumulator word), cfg (active config), y (quantised word), sat.
module vau_lane
  import vau_pkg::*;
#(
  parameter int ACC_W = VAU_ACC_W,
  parameter int OUT_W = VAU_OUT_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic signed [ACC_W-1:0] x,
  input  vau_cfg_t                cfg,
  output logic signed [OUT_W-1:0] y,
  output logic                    sat
);
  // PW holds the exact product; XW adds headroom for rounding and bias/zero-point adds.
  localparam int PW = ACC_W + 16;
  localparam int XW = ACC_W + 18;

  logic signed [ACC_W-1:0] act_c;
  logic signed [ACC_W-1:0] a_q;
  logic signed [PW-1:0]    p_q;
  logic signed [XW-1:0]    rnd_c;
  logic signed [XW-1:0]    n_full_c;
  logic signed [ACC_W-1:0] n_c;
  logic                    sat3_c;
  logic signed [ACC_W-1:0] n_q;
  logic                    sat3_q;
  logic signed [PW-1:0]    q_q;
  logic                    sat4_q;
  logic signed [XW-1:0]    r_full_c;
  logic signed [OUT_W-1:0] r_c;
  logic                    sat5_c;

  // S1: activation
  always_comb begin
    act_c = x;
    case (cfg.mode)
      ACT_RELU:  act_c = x[ACC_W-1] ? '0 : x;
      ACT_CLIP: begin
        act_c = x[ACC_W-1] ? '0 : x;
        if (act_c > $signed(cfg.clip_max)) act_c = cfg.clip_max;
      end
      ACT_LEAKY: act_c = x[ACC_W-1] ? (x >>> cfg.leak_shift) : x;
      default:   act_c = x;
    endcase
  end

  // S3: round-half-up right shift plus bias. (1<<shift)>>1 is 0 for shift 0, else 1<<(shift-1).
  always_comb begin
    rnd_c    = (XW'(1) << cfg.shift) >> 1;
    n_full_c = ((XW'(p_q) + rnd_c) >>> cfg.shift) + XW'($signed(cfg.bias));
    n_c      = ACC_W'(sat_signed(64'(n_full_c), ACC_W, sat3_c));
  end

  // S5: Q8.8 rescale with rounding, zero point, clamp to the output word.
  always_comb begin
    r_full_c = ((XW'(q_q) + XW'(Q_ROUND)) >>> Q_FRAC) + XW'($signed(cfg.zero_point));
    r_c      = OUT_W'(sat_signed(64'(r_full_c), OUT_W, sat5_c));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q    <= '0;
      p_q    <= '0;
      n_q    <= '0;
      sat3_q <= 1'b0;
      q_q    <= '0;
      sat4_q <= 1'b0;
      y      <= '0;
      sat    <= 1'b0;
    end else if (en) begin
      a_q    <= act_c;
      p_q    <= PW'(a_q) * PW'($signed(cfg.gain));
      n_q    <= n_c;
      sat3_q <= sat3_c;
      q_q    <= PW'(n_q) * PW'($signed(cfg.inv_scale));
      sat4_q <= sat3_q;
      y      <= r_c;
      sat    <= sat4_q | sat5_c;
    end
  end

endmodule

// File: rtl/vector_activation_unit.sv
// vector_activation_unit: LANES-wide activation/normalise/quantise pipeline after the accumulators.
// Latency 5 cycles, 1 beat/cycle; the whole pipe advances on en = !out_valid || out_ready.
// Backpressure: in_ready = en (low in reset); a stalled output beat holds out_data/out_sat stable.
// Ports: clk, reset_n, bus (beat streams), cfg_* (latched on idle cfg_load), busy, sat_count, sat_clear.
module vector_activation_unit
  import vau_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int ACC_W   = VAU_ACC_W,
  parameter int OUT_W   = VAU_OUT_W,
  parameter int SHIFT_W = VAU_SHIFT_W,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  vector_activation_unit_if.slave   bus,
  input  logic                      cfg_load,
  input  logic [1:0]                cfg_mode,
  input  logic signed [ACC_W-1:0]   cfg_clip_max,
  input  logic [SHIFT_W-1:0]        cfg_leak_shift,
  input  logic signed [15:0]        cfg_gain,
  input  logic [SHIFT_W-1:0]        cfg_shift,
  input  logic signed [ACC_W-1:0]   cfg_bias,
  input  logic signed [15:0]        cfg_inv_scale,
  input  logic signed [OUT_W-1:0]   cfg_zero_point,
  output logic                      busy,
  output logic [CNT_W-1:0]          sat_count,
  input  logic                      sat_clear
);
  logic [4:0]             vld_q;  // vld_q[k]: stage k+1 holds a beat; vld_q[4] is out_valid
  logic                   en;
  logic                   accept;
  vau_cfg_t               cfg_q;
  logic [LANES*OUT_W-1:0] out_data_w;
  logic [LANES-1:0]       out_sat_w;

  assign en            = !vld_q[4] || bus.out_ready;
  assign bus.in_ready  = reset_n && en;
  assign accept        = bus.in_valid && bus.in_ready;
  assign busy          = |vld_q;
  assign bus.out_valid = vld_q[4];
  assign bus.out_data  = out_data_w;
  assign bus.out_sat   = out_sat_w;

  // Bubbles travel with the data, so the valid chain shifts as a whole on en.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vld_q <= '0;
    else if (en)  vld_q <= {vld_q[3:0], accept};
  end

  // Config only changes with the pipe empty and no beat entering, so every beat
  // sees a single config from entry to exit without per-stage copies.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_q <= CFG_RESET;
    end else if (cfg_load && !busy && !accept) begin
      cfg_q <= '{
        mode:       act_mode_e'(cfg_mode),
        clip_max:   cfg_clip_max,
        leak_shift: cfg_leak_shift,
        gain:       cfg_gain,
        shift:      cfg_shift,
        bias:       cfg_bias,
        inv_scale:  cfg_inv_scale,
        zero_point: cfg_zero_point
      };
    end
  end

  // Counts beats handed downstream with any lane clamped; sticks at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_count <= '0;
    end else if (sat_clear) begin
      sat_count <= '0;
    end else if (vld_q[4] && en && (|out_sat_w) && !(&sat_count)) begin
      sat_count <= sat_count + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vau_lane #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (en),
      .x       (bus.in_data[g*ACC_W +: ACC_W]),
      .cfg     (cfg_q),
      .y       (out_data_w[g*OUT_W +: OUT_W]),
      .sat     (out_sat_w[g])
    );
  end

endmodule
